// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: 2048-clock period, duty/direction shadowed at the
// period wrap, dead-time blanking after every direction reversal.

module mtr_drv_side #(
  parameter int DEAD_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] i_cnt,
  input  logic        i_load,
  input  logic [10:0] i_spd,
  input  logic        i_rev,
  output logic        o_frwrd,
  output logic        o_rev
);

  typedef enum logic {DRIVE = 1'b0, DEAD = 1'b1} state_t;

  localparam logic [10:0] DEAD_LD = 11'(DEAD_CYC);

  state_t      r_state;
  state_t      w_nxt_state;
  logic [10:0] r_dead_cnt;
  logic [10:0] w_nxt_dead_cnt;
  logic [10:0] r_spd_q;
  logic        r_rev_q;
  logic        r_frwrd;
  logic        r_rev;
  logic        w_blank_req;
  logic        w_raw;
  logic        w_drive;

  // Reversal is judged against the direction still held in the shadow register.
  assign w_blank_req = i_load && (i_rev != r_rev_q) && (DEAD_LD != 11'd0);
  assign w_raw       = (i_cnt < r_spd_q);
  assign w_drive     = (r_state == DRIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DRIVE;
      r_dead_cnt <= 11'd0;
    end else begin
      r_state    <= w_nxt_state;
      r_dead_cnt <= w_nxt_dead_cnt;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_dead_cnt = r_dead_cnt;
    if (w_blank_req) begin
      w_nxt_state    = DEAD;
      w_nxt_dead_cnt = DEAD_LD;
    end else begin
      case (r_state)
        DRIVE: begin
          w_nxt_state    = DRIVE;
          w_nxt_dead_cnt = 11'd0;
        end
        DEAD: begin
          if (r_dead_cnt <= 11'd1) begin
            w_nxt_state    = DRIVE;
            w_nxt_dead_cnt = 11'd0;
          end else begin
            w_nxt_state    = DEAD;
            w_nxt_dead_cnt = r_dead_cnt - 11'd1;
          end
        end
        default: begin
          w_nxt_state    = DRIVE;
          w_nxt_dead_cnt = 11'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spd_q <= 11'd0;
      r_rev_q <= 1'b0;
      r_frwrd <= 1'b0;
      r_rev   <= 1'b0;
    end else begin
      if (i_load) begin
        r_spd_q <= i_spd;
        r_rev_q <= i_rev;
      end
      r_frwrd <= w_raw & ~r_rev_q & w_drive;
      r_rev   <= w_raw &  r_rev_q & w_drive;
    end
  end

  assign o_frwrd = r_frwrd;
  assign o_rev   = r_rev;

endmodule

module mtr_drv #(
  parameter int DEAD_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] lft_spd,
  input  logic        lft_rev,
  input  logic [10:0] rght_spd,
  input  logic        rght_rev,
  output logic        PWM_frwrd_lft,
  output logic        PWM_rev_lft,
  output logic        PWM_frwrd_rght,
  output logic        PWM_rev_rght,
  output logic        pwm_sync
);

  logic [10:0] r_cnt;
  logic        r_sync;
  logic        w_load;

  assign w_load = (r_cnt == 11'd2047);

  // Sync is registered alongside the gates so it lines up with the cnt == 0 outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 11'd0;
      r_sync <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + 11'd1;
      r_sync <= (r_cnt == 11'd0);
    end
  end

  assign pwm_sync = r_sync;

  mtr_drv_side #(.DEAD_CYC(DEAD_CYC)) u_lft (
    .clk     (clk),
    .rst     (rst),
    .i_cnt   (r_cnt),
    .i_load  (w_load),
    .i_spd   (lft_spd),
    .i_rev   (lft_rev),
    .o_frwrd (PWM_frwrd_lft),
    .o_rev   (PWM_rev_lft)
  );

  mtr_drv_side #(.DEAD_CYC(DEAD_CYC)) u_rght (
    .clk     (clk),
    .rst     (rst),
    .i_cnt   (r_cnt),
    .i_load  (w_load),
    .i_spd   (rght_spd),
    .i_rev   (rght_rev),
    .o_frwrd (PWM_frwrd_rght),
    .o_rev   (PWM_rev_rght)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboard bench for mtr_drv: per-period expected gate statistics are queued
// by the stimulus process and checked by a monitor that frames on pwm_sync.

module tb_mtr_drv;

  localparam int DEAD = 64;
  localparam int PER  = 2048;

  logic        clk;
  logic        rst;
  logic [10:0] lft_spd;
  logic        lft_rev;
  logic [10:0] rght_spd;
  logic        rght_rev;
  logic        PWM_frwrd_lft;
  logic        PWM_rev_lft;
  logic        PWM_frwrd_rght;
  logic        PWM_rev_rght;
  logic        pwm_sync;

  int checks;
  int failures;
  int expq[$];
  int prev_rev[2];

  int tbl_ls[7] = '{512, 0, 2047, 1000, 40, 64, 65};
  int tbl_lr[7] = '{0, 0, 0, 1, 0, 1, 1};
  int tbl_rs[7] = '{100, 1500, 1500, 1500, 700, 0, 2047};
  int tbl_rr[7] = '{0, 0, 1, 1, 1, 0, 0};

  mtr_drv #(.DEAD_CYC(DEAD)) dut (
    .clk            (clk),
    .rst            (rst),
    .lft_spd        (lft_spd),
    .lft_rev        (lft_rev),
    .rght_spd       (rght_spd),
    .rght_rev       (rght_rev),
    .PWM_frwrd_lft  (PWM_frwrd_lft),
    .PWM_rev_lft    (PWM_rev_lft),
    .PWM_frwrd_rght (PWM_frwrd_rght),
    .PWM_rev_rght   (PWM_rev_rght),
    .pwm_sync       (pwm_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Expected statistics for one side over a whole period: fwd count, rev count, first/last high index.
  function automatic void push_side(int spd, int rev, int prev);
    int dead;
    int n;
    dead = (rev != prev && DEAD != 0) ? DEAD : 0;
    n    = (spd > dead) ? spd - dead : 0;
    expq.push_back(rev ? 0 : n);
    expq.push_back(rev ? n : 0);
    expq.push_back(n > 0 ? dead : -1);
    expq.push_back(n > 0 ? spd - 1 : -1);
  endfunction

  function automatic int rand_spd();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 2047;
      2:       return DEAD + $urandom_range(0, 1);
      3:       return $urandom_range(0, 100);
      default: return $urandom_range(0, 2047);
    endcase
  endfunction

  // Starts at the negedge where the DUT's cnt is 0; each pass covers one period.
  task automatic stim(input int nper, input bit directed);
    int ls, lr, rs, rr, a;
    for (int m = 0; m < nper; m++) begin
      if (directed && m < 7) begin
        ls = tbl_ls[m]; lr = tbl_lr[m]; rs = tbl_rs[m]; rr = tbl_rr[m];
        a  = 50;
      end else begin
        ls = rand_spd(); lr = $urandom_range(0, 1);
        rs = rand_spd(); rr = $urandom_range(0, 1);
        a  = $urandom_range(1, 2000);
      end
      repeat (a) @(negedge clk);
      lft_spd  = 11'(ls);
      lft_rev  = (lr != 0);
      rght_spd = 11'(rs);
      rght_rev = (rr != 0);
      repeat (PER - 1 - a) @(negedge clk);
      push_side(ls, lr, prev_rev[0]);
      push_side(rs, rr, prev_rev[1]);
      prev_rev[0] = lr;
      prev_rev[1] = rr;
      @(negedge clk);
    end
  endtask

  task automatic mon(input int nper);
    int got;
    int sync_err;
    int nf[2], nr[2], fi[2], la[2], ovl[2];
    logic f[2], r[2];
    got = 0;
    for (int w = 0; w < 2 * PER && got == 0; w++) begin
      @(negedge clk);
      if (pwm_sync) got = 1;
    end
    chk("sync_seen", got, 1);
    if (got == 0) return;
    for (int p = 0; p < nper; p++) begin
      sync_err = 0;
      for (int s = 0; s < 2; s++) begin
        nf[s] = 0; nr[s] = 0; fi[s] = -1; la[s] = -1; ovl[s] = 0;
      end
      for (int i = 0; i < PER; i++) begin
        if (p > 0 || i > 0) @(negedge clk);
        if (pwm_sync != (i == 0)) sync_err++;
        f[0] = PWM_frwrd_lft;  r[0] = PWM_rev_lft;
        f[1] = PWM_frwrd_rght; r[1] = PWM_rev_rght;
        for (int s = 0; s < 2; s++) begin
          if (f[s]) nf[s]++;
          if (r[s]) nr[s]++;
          if (f[s] || r[s]) begin
            if (fi[s] < 0) fi[s] = i;
            la[s] = i;
          end
          if (f[s] && r[s]) ovl[s]++;
        end
      end
      chk("sync_period", sync_err, 0);
      if (expq.size() < 8) begin
        chk("exp_queue_depth", expq.size(), 8);
      end else begin
        for (int s = 0; s < 2; s++) begin
          chk(s == 0 ? "lft_fwd_count"  : "rght_fwd_count",  nf[s], expq.pop_front());
          chk(s == 0 ? "lft_rev_count"  : "rght_rev_count",  nr[s], expq.pop_front());
          chk(s == 0 ? "lft_first_high" : "rght_first_high", fi[s], expq.pop_front());
          chk(s == 0 ? "lft_last_high"  : "rght_last_high",  la[s], expq.pop_front());
          chk(s == 0 ? "lft_overlap"    : "rght_overlap",    ovl[s], 0);
        end
      end
    end
  endtask

  // Called at the negedge where reset is released; period 0 is all-low.
  task automatic run_phase(input int nper, input bit directed);
    expq.delete();
    prev_rev[0] = 0;
    prev_rev[1] = 0;
    push_side(0, 0, 0);
    push_side(0, 0, 0);
    fork
      stim(nper, directed);
      mon(nper + 1);
    join
  endtask

  task automatic chk_all_low(string tag);
    chk({tag, "_frwrd_lft"},  int'(PWM_frwrd_lft),  0);
    chk({tag, "_rev_lft"},    int'(PWM_rev_lft),    0);
    chk({tag, "_frwrd_rght"}, int'(PWM_frwrd_rght), 0);
    chk({tag, "_rev_rght"},   int'(PWM_rev_rght),   0);
    chk({tag, "_sync"},       int'(pwm_sync),       0);
  endtask

  initial begin
    int cl, cr;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    lft_spd  = 11'd0;
    lft_rev  = 1'b0;
    rght_spd = 11'd0;
    rght_rev = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_low("reset");
    rst = 1'b0;
    run_phase(15, 1'b1);

    // Now at cnt == 0: request a left reversal while the right keeps direction.
    cl = prev_rev[0];
    cr = prev_rev[1];
    lft_spd  = 11'd1000;
    lft_rev  = (cl == 0);
    rght_spd = 11'd1500;
    rght_rev = (cr != 0);
    repeat (PER) @(negedge clk);
    repeat (31) @(negedge clk);
    chk("dead_frwrd_lft", int'(PWM_frwrd_lft), 0);
    chk("dead_rev_lft",   int'(PWM_rev_lft),   0);
    chk("live_frwrd_rght", int'(PWM_frwrd_rght), (cr == 0) ? 1 : 0);
    chk("live_rev_rght",   int'(PWM_rev_rght),   (cr != 0) ? 1 : 0);
    #2 rst = 1'b1;
    #1 chk_all_low("async_rst");
    repeat (4) @(negedge clk);
    chk_all_low("rst_held");
    rst = 1'b0;
    run_phase(3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
# mtr_drv

Motor PWM driver sitting directly downstream of the digital core. It consumes the 11-bit left/right speed magnitudes and reverse flags from the balance controller and converts them into forward/reverse PWM gate signals for the two H-bridges. Duty cycle and direction are updated only at PWM period boundaries. Dead-time blanking is inserted on every direction reversal so that opposite legs of a bridge are never driven back-to-back. A period-start strobe is exported for synchronizing the A2D sampling of bridge currents.

## Interface
- DEAD_CYC, 64, blanking length in clocks after a direction reversal; legal range 0..2047; 0 disables blanking

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- lft_spd  in  11  left motor duty magnitude, unsigned
- lft_rev  in  1  left motor direction, 1 = reverse
- rght_spd  in  11  right motor duty magnitude, unsigned
- rght_rev  in  1  right motor direction, 1 = reverse
- PWM_frwrd_lft  out  1  left bridge forward gate
- PWM_rev_lft  out  1  left bridge reverse gate
- PWM_frwrd_rght  out  1  right bridge forward gate
- PWM_rev_rght  out  1  right bridge reverse gate
- pwm_sync  out  1  one-clock strobe marking the start of each PWM period

## Operation
- Period counter `cnt`:
  - 11-bit, free-running, increments every clk.
  - Wraps 2047 -> 0, giving a period of 2048 clocks.
- Shadow load:
  - On the cycle where cnt == 2047, load spd_q <= spd and rev_q <= rev for each side.
  - Inputs are otherwise ignored; mid-period input changes have no effect until the next wrap.
- Raw PWM per side: raw = (cnt < spd_q), an unsigned 11-bit compare.
  - spd_q = 0: output always low.
  - spd_q = 2047: output high 2047 of 2048 clocks.
  - Full 100% duty is not reachable, by design.
- Per-side dead-time FSM, states DRIVE and DEAD:
  - DRIVE -> DEAD: at the shadow-load cycle, when the newly loaded rev differs from the current rev_q and DEAD_CYC != 0.
  - On that transition, dead_cnt is loaded with DEAD_CYC.
  - In DEAD, dead_cnt decrements each clock. DEAD -> DRIVE when dead_cnt reaches 1.
  - Both gates of that side are forced low while in DEAD.
  - A new reversal request at the next wrap while still in DEAD reloads dead_cnt. This is only possible if DEAD_CYC exceeds 2048, which is illegal.
- Gate outputs:
  - PWM_frwrd = raw & ~rev_q & (state == DRIVE)
  - PWM_rev = raw & rev_q & (state == DRIVE)
  - Forward and reverse gates of one side are never high in the same cycle.
- Left and right channels are fully independent. Both share cnt and pwm_sync.
- pwm_sync is high for exactly one clock per period, aligned with the first clock of the new period's outputs.

## Timing
- All outputs are registered. The output value at cycle t+1 is computed from cnt, spd_q, rev_q and state at cycle t.
- Input to output latency: a change on spd/rev first affects the gate outputs on the clock after cnt passes from 0 to 1, i.e. at the first output cycle of the next period. Worst case is 2049 clocks.
- Dead-time placement: after a reversal, gates are low for the first DEAD_CYC output cycles of the period (compare values cnt = 0..DEAD_CYC-1). Normal PWM for the new direction starts at cnt = DEAD_CYC.
  - If spd_q <= DEAD_CYC, the side stays low for the whole period.
- pwm_sync is asserted in the cycle whose outputs reflect cnt = 0.
- Reset (async, active-high, immediate):
  - cnt = 0, spd_q = 0, rev_q = 0, state = DRIVE, dead_cnt = 0.
  - All four PWM outputs = 0, pwm_sync = 0.
  - Reset asserted mid-period or mid-DEAD aborts everything and forces all outputs low immediately.
  - After release, outputs stay low until the first shadow load at cnt == 2047. The first reversal relative to the reset direction (forward) also triggers DEAD.
- A simultaneous spd and rev change at the same wrap means both take effect together: blanking first, then the new duty.

## Test plan
- Reset, then hold lft_spd = 512, lft_rev = 0 -> PWM_frwrd_lft high for exactly 512 of every 2048 clocks, PWM_rev_lft always 0, pwm_sync period = 2048.
- lft_spd = 0, then 2047 -> gate low for the whole period; then high 2047 / low 1 per period; change visible only at the next period start.
- Mid-period change of rght_spd from 100 to 1500 at cnt = 50 -> current period keeps duty 100; the next period has duty 1500.
- lft_spd = 1000, flip lft_rev 0 -> 1 -> next period: both gates low for 64 clocks, PWM_rev_lft high for clocks 64..999, never any overlap with PWM_frwrd_lft.
- Reversal with lft_spd = 40 and DEAD_CYC = 64 -> both left gates low for the entire period; right channel is unaffected throughout.
- Assert rst during DEAD at cnt = 30 -> all outputs 0 within the same cycle. After release, outputs stay 0 until the first load at cnt == 2047; then normal duty resumes.
